// File: rtl/alu_tr_scheduler.sv
// Execute-stage sequencer for a time-redundant ALU with a spare: double-executes each op
// on the primary ALU, falls back to the spare on mismatch, and retires the primary after repeated faults.
module alu_tr_scheduler #(
    parameter int WIDTH        = 32,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_res_p,
    input  logic [WIDTH-1:0] alu_res_s,
    output logic             stall,
    output logic             ex_update_en,
    output logic [WIDTH-1:0] result_o,
    output logic             res_sel,
    output logic             fault_detected,
    output logic             spare_active,
    output logic [CNT_W-1:0] fault_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        T1 = 2'b00,
        T2 = 2'b01,
        T3 = 2'b10,
        SP = 2'b11
    } stateT;

    localparam logic [31:0] THRESH = FAULT_THRESH;

    stateT             state;
    stateT             stateNext;
    logic [WIDTH-1:0]  resT1;
    logic [CNT_W-1:0]  faultCnt;
    logic              spareAct;
    logic              armed;
    logic              loadT1;
    logic              faultPulse;
    logic              setSpare;
    logic              threshHit;

    // armed holds every output low through reset and the first edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= T1;
            resT1    <= '0;
            faultCnt <= '0;
            spareAct <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= stateNext;
            if (loadT1)
                resT1 <= alu_res_p;
            if (faultPulse && (faultCnt != '1))
                faultCnt <= faultCnt + 1'b1;
            if (setSpare)
                spareAct <= 1'b1;
        end
    end

    assign threshHit = (32'(faultCnt) >= THRESH);

    always_comb begin
        stateNext      = state;
        stall          = 1'b0;
        ex_update_en   = 1'b0;
        result_o       = '0;
        res_sel        = 1'b0;
        faultPulse     = 1'b0;
        loadT1         = 1'b0;
        setSpare       = 1'b0;
        if (armed) begin
            case (state)
                T1: begin
                    if (op_valid && !flush) begin
                        loadT1    = 1'b1;
                        stall     = 1'b1;
                        stateNext = T2;
                    end
                end
                T2: begin
                    // flush wins over the compare so a squashed op never counts as a fault
                    if (flush) begin
                        stateNext = T1;
                    end else if (alu_res_p == resT1) begin
                        ex_update_en = 1'b1;
                        result_o     = resT1;
                        stateNext    = T1;
                    end else begin
                        faultPulse = 1'b1;
                        stall      = 1'b1;
                        stateNext  = T3;
                    end
                end
                T3: begin
                    res_sel = 1'b1;
                    if (flush) begin
                        stateNext = T1;
                    end else begin
                        ex_update_en = 1'b1;
                        result_o     = alu_res_s;
                        if (threshHit) begin
                            setSpare  = 1'b1;
                            stateNext = SP;
                        end else begin
                            stateNext = T1;
                        end
                    end
                end
                SP: begin
                    res_sel      = 1'b1;
                    ex_update_en = op_valid && !flush;
                    if (op_valid && !flush)
                        result_o = alu_res_s;
                end
                default: stateNext = T1;
            endcase
        end
    end

    assign fault_detected = faultPulse;
    assign spare_active   = spareAct;
    assign fault_count    = faultCnt;
    assign state_o        = state;

endmodule

// File: tb/tb_alu_tr_scheduler.sv
// Directed bench for alu_tr_scheduler: cycle table for the main flows plus hand sequences
// for reset-in-T3 and counter saturation on a narrow-counter instance.
module tb_alu_tr_scheduler;

    typedef struct {
        logic        ov;
        logic        fl;
        logic [31:0] p;
        logic [31:0] s;
        logic        stall;
        logic        upd;
        logic [31:0] res;
        logic        sel;
        logic        flt;
        logic        spa;
        logic [1:0]  st;
        logic [7:0]  cnt;
    } vecT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        opValid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] resP = '0;
    logic [31:0] resS = '0;

    logic        stallA, updA, selA, fltA, spaA;
    logic [31:0] resA;
    logic [7:0]  cntA;
    logic [1:0]  stA;

    logic        stallB, updB, selB, fltB, spaB;
    logic [31:0] resB;
    logic [1:0]  cntB;
    logic [1:0]  stB;

    int testCount = 0;
    int failCount = 0;
    vecT vecs[19];

    always #5 clk = ~clk;

    alu_tr_scheduler #(.WIDTH(32), .FAULT_THRESH(3), .CNT_W(8)) dutA (
        .clk(clk), .rst(rst), .op_valid(opValid), .flush(flush),
        .alu_res_p(resP), .alu_res_s(resS),
        .stall(stallA), .ex_update_en(updA), .result_o(resA), .res_sel(selA),
        .fault_detected(fltA), .spare_active(spaA), .fault_count(cntA), .state_o(stA)
    );

    alu_tr_scheduler #(.WIDTH(32), .FAULT_THRESH(4), .CNT_W(2)) dutB (
        .clk(clk), .rst(rst), .op_valid(opValid), .flush(flush),
        .alu_res_p(resP), .alu_res_s(resS),
        .stall(stallB), .ex_update_en(updB), .result_o(resB), .res_sel(selB),
        .fault_detected(fltB), .spare_active(spaB), .fault_count(cntB), .state_o(stB)
    );

    task automatic checkVal(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ov, input logic fl, input logic [31:0] p, input logic [31:0] s);
        @(negedge clk);
        opValid = ov;
        flush   = fl;
        resP    = p;
        resS    = s;
        #1;
    endtask

    task automatic checkOutput(input int idx, input vecT v);
        checkVal("stall", idx, 32'(stallA), 32'(v.stall));
        checkVal("ex_update_en", idx, 32'(updA), 32'(v.upd));
        checkVal("result_o", idx, resA, v.res);
        checkVal("res_sel", idx, 32'(selA), 32'(v.sel));
        checkVal("fault_detected", idx, 32'(fltA), 32'(v.flt));
        checkVal("spare_active", idx, 32'(spaA), 32'(v.spa));
        checkVal("state_o", idx, 32'(stA), 32'(v.st));
        checkVal("fault_count", idx, 32'(cntA), 32'(v.cnt));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        opValid = 1'b0;
        flush = 1'b0;
        resP = '0;
        resS = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        //            ov  fl  p      s      stl upd res    sel flt spa st  cnt
        vecs[0]  = '{0, 0, 32'h00, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 32'h05, 32'h00, 1, 0, 32'h00, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 32'h05, 32'h00, 0, 1, 32'h05, 0, 0, 0, 1, 0};
        vecs[3]  = '{1, 0, 32'h10, 32'h10, 1, 0, 32'h00, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 32'h11, 32'h10, 1, 0, 32'h00, 0, 1, 0, 1, 0};
        vecs[5]  = '{1, 0, 32'h11, 32'h10, 0, 1, 32'h10, 1, 0, 0, 2, 1};
        vecs[6]  = '{0, 0, 32'h00, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 1};
        vecs[7]  = '{1, 0, 32'h20, 32'h00, 1, 0, 32'h00, 0, 0, 0, 0, 1};
        vecs[8]  = '{1, 1, 32'h21, 32'h00, 0, 0, 32'h00, 0, 0, 0, 1, 1};
        vecs[9]  = '{0, 0, 32'h00, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 1};
        vecs[10] = '{1, 0, 32'h30, 32'h30, 1, 0, 32'h00, 0, 0, 0, 0, 1};
        vecs[11] = '{1, 0, 32'h31, 32'h30, 1, 0, 32'h00, 0, 1, 0, 1, 1};
        vecs[12] = '{1, 0, 32'h31, 32'h30, 0, 1, 32'h30, 1, 0, 0, 2, 2};
        vecs[13] = '{1, 0, 32'h40, 32'h42, 1, 0, 32'h00, 0, 0, 0, 0, 2};
        vecs[14] = '{1, 0, 32'h41, 32'h42, 1, 0, 32'h00, 0, 1, 0, 1, 2};
        vecs[15] = '{1, 0, 32'h41, 32'h42, 0, 1, 32'h42, 1, 0, 0, 2, 3};
        vecs[16] = '{1, 0, 32'h50, 32'h51, 0, 1, 32'h51, 1, 0, 1, 3, 3};
        vecs[17] = '{1, 1, 32'h50, 32'h52, 0, 0, 32'h00, 1, 0, 1, 3, 3};
        vecs[18] = '{0, 0, 32'h50, 32'h53, 0, 0, 32'h00, 1, 0, 1, 3, 3};

        // reset state observed while rst is low, with a valid op presented
        rst = 1'b0;
        opValid = 1'b1;
        resP = 32'h5;
        #12;
        checkVal("reset_stall", 0, 32'(stallA), 32'd0);
        checkVal("reset_state", 0, 32'(stA), 32'd0);
        checkVal("reset_count", 0, 32'(cntA), 32'd0);

        doReset();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].ov, vecs[i].fl, vecs[i].p, vecs[i].s);
            checkOutput(i, vecs[i]);
        end

        // asynchronous reset asserted mid-T3
        doReset();
        applyStimulus(1, 0, 32'h1, 32'h0);
        applyStimulus(1, 0, 32'h2, 32'h3);
        applyStimulus(1, 0, 32'h2, 32'h3);
        checkVal("t3_state", 100, 32'(stA), 32'd2);
        checkVal("t3_result", 100, resA, 32'h3);
        #2;
        rst = 1'b0;
        #1;
        checkVal("rst_t3_stall", 101, 32'(stallA), 32'd0);
        checkVal("rst_t3_update", 101, 32'(updA), 32'd0);
        checkVal("rst_t3_result", 101, resA, 32'd0);
        checkVal("rst_t3_res_sel", 101, 32'(selA), 32'd0);
        checkVal("rst_t3_state", 101, 32'(stA), 32'd0);
        checkVal("rst_t3_count", 101, 32'(cntA), 32'd0);
        checkVal("rst_t3_spare", 101, 32'(spaA), 32'd0);

        // five faults on the 2-bit counter instance with an unreachable threshold
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 32'(k * 16), 32'h7);
            applyStimulus(1, 0, 32'(k * 16 + 1), 32'h7);
            applyStimulus(1, 0, 32'(k * 16 + 1), 32'h7);
        end
        applyStimulus(0, 0, 32'h0, 32'h0);
        checkVal("sat_count", 200, 32'(cntB), 32'd3);
        checkVal("sat_spare", 200, 32'(spaB), 32'd0);
        checkVal("sat_state", 200, 32'(stB), 32'd0);
        checkVal("thresh_spare", 200, 32'(spaA), 32'd1);
        checkVal("thresh_state", 200, 32'(stA), 32'd3);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
